// File: rtl/pixel_frame_ctrl_if.sv
// Pixel stream bundle: camera-side input pixels and the registered, coordinate-tagged
// stream handed on to the frame-buffer DMA writer.
interface pixel_frame_ctrl_if #(
  parameter int COORD_W = 12
);
  logic               valid;
  logic [7:0]         iRed;
  logic [7:0]         iGreen;
  logic [7:0]         iBlue;
  logic               oValid;
  logic [7:0]         oRed;
  logic [7:0]         oGreen;
  logic [7:0]         oBlue;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic               sof;
  logic               eol;
  logic               eof;

  // Upstream source: drives input pixels and observes the tagged output stream
  modport master (
    output valid, iRed, iGreen, iBlue,
    input  oValid, oRed, oGreen, oBlue, x_coord, y_coord, sof, eol, eof
  );

  modport slave (
    input  valid, iRed, iGreen, iBlue,
    output oValid, oRed, oGreen, oBlue, x_coord, y_coord, sof, eol, eof
  );
endinterface

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: arms on start, tags each accepted pixel with x/y and sof/eol/eof
// markers, and stops after a programmed frame count (0 runs forever).
module pixel_frame_ctrl #(
  parameter int COORD_W = 12,
  parameter int FCNT_W  = 8
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [COORD_W-1:0]  cfg_width,
  input  logic [COORD_W-1:0]  cfg_height,
  input  logic [FCNT_W-1:0]   cfg_frames,
  pixel_frame_ctrl_if.slave   px,
  output logic                busy,
  output logic                done,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic [15:0]         drop_cnt,
  output logic                cfg_err
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

  state_t             state, next_state;
  logic [COORD_W-1:0] lat_width, lat_height;
  logic [FCNT_W-1:0]  lat_frames;
  logic [COORD_W-1:0] x, y;
  logic [FCNT_W-1:0]  frame_next;
  logic               cfg_ok;
  logic               at_eol, at_eof, last_frame;
  logic               accept, arm, reject, drop;

  assign cfg_ok     = (cfg_width != '0) && (cfg_height != '0);
  assign at_eol     = (x == lat_width - COORD_W'(1));
  assign at_eof     = at_eol && (y == lat_height - COORD_W'(1));
  assign frame_next = frame_cnt + FCNT_W'(1);
  // Only a nonzero programmed count can terminate; zero means continuous capture
  assign last_frame = at_eof && (lat_frames != '0) && (frame_next == lat_frames);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    arm        = 1'b0;
    reject     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE, DONE: begin
        drop = px.valid;
        if (start && !abort) begin
          if (cfg_ok) begin
            arm        = 1'b1;
            next_state = ARMED;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ARMED, ACTIVE: begin
        if (px.valid && !abort) begin
          accept     = 1'b1;
          next_state = last_frame ? DONE : ACTIVE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      lat_width  <= '0;
      lat_height <= '0;
      lat_frames <= '0;
      x          <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      px.oValid  <= 1'b0;
      px.oRed    <= '0;
      px.oGreen  <= '0;
      px.oBlue   <= '0;
      px.x_coord <= '0;
      px.y_coord <= '0;
      px.sof     <= 1'b0;
      px.eol     <= 1'b0;
      px.eof     <= 1'b0;
    end else begin
      if (abort) begin
        x <= '0;
        y <= '0;
      end else if (arm) begin
        lat_width  <= cfg_width;
        lat_height <= cfg_height;
        lat_frames <= cfg_frames;
        frame_cnt  <= '0;
        x          <= '0;
        y          <= '0;
      end else if (accept) begin
        if (at_eol) begin
          x <= '0;
          if (at_eof) begin
            y         <= '0;
            frame_cnt <= frame_next;
          end else begin
            y <= y + COORD_W'(1);
          end
        end else begin
          x <= x + COORD_W'(1);
        end
      end

      // Markers are qualified by accept so they never appear without oValid
      px.oValid <= accept;
      px.sof    <= accept && (x == '0) && (y == '0);
      px.eol    <= accept && at_eol;
      px.eof    <= accept && at_eof;
      if (accept) begin
        px.oRed    <= px.iRed;
        px.oGreen  <= px.iGreen;
        px.oBlue   <= px.iBlue;
        px.x_coord <= x;
        px.y_coord <= y;
      end

      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      cfg_err <= reject;
      busy    <= (next_state == ARMED) || (next_state == ACTIVE);
      done    <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: table vectors, directed multi-cycle sequences and random
// traffic, all compared against a pixel-index based reference model.
module tb_pixel_frame_ctrl;

  logic        pixclk = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic [11:0] cfg_width  = '0;
  logic [11:0] cfg_height = '0;
  logic [7:0]  cfg_frames = '0;
  logic        busy, done, cfg_err;
  logic [7:0]  frame_cnt;
  logic [15:0] drop_cnt;

  pixel_frame_ctrl_if #(.COORD_W(12)) px ();

  pixel_frame_ctrl #(.COORD_W(12), .FCNT_W(8)) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_frames (cfg_frames),
    .px         (px),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 pixclk = ~pixclk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position is a linear pixel index; x/y are derived from it
  int m_running, m_finished, m_idx, m_frames, m_drops, m_w, m_h, m_f;
  int e_ovalid, e_r, e_g, e_b, e_x, e_y, e_sof, e_eol, e_eof, e_err;
  int n_sof, n_eol, n_eof;

  typedef struct {
    int s, a, v, w, h, f;
    int ov, sof, eol, eof, busy, done, err, fcnt;
  } vec_t;
  vec_t vecs[9];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_running = 0; m_finished = 0; m_idx = 0; m_frames = 0; m_drops = 0;
    m_w = 0; m_h = 0; m_f = 0;
    e_ovalid = 0; e_r = 0; e_g = 0; e_b = 0; e_x = 0; e_y = 0;
    e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
  endtask

  task automatic checkOutput();
    checkVal("oValid", int'(px.oValid), e_ovalid);
    if (e_ovalid != 0) begin
      checkVal("oRed", int'(px.oRed), e_r);
      checkVal("oGreen", int'(px.oGreen), e_g);
      checkVal("oBlue", int'(px.oBlue), e_b);
      checkVal("x_coord", int'(px.x_coord), e_x);
      checkVal("y_coord", int'(px.y_coord), e_y);
    end
    checkVal("sof", int'(px.sof), e_sof);
    checkVal("eol", int'(px.eol), e_eol);
    checkVal("eof", int'(px.eof), e_eof);
    checkVal("busy", int'(busy), m_running);
    checkVal("done", int'(done), m_finished);
    checkVal("frame_cnt", int'(frame_cnt), m_frames);
    checkVal("drop_cnt", int'(drop_cnt), m_drops);
    checkVal("cfg_err", int'(cfg_err), e_err);
    n_sof += int'(px.sof);
    n_eol += int'(px.eol);
    n_eof += int'(px.eof);
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge
  task automatic applyStimulus(input int s, input int a, input int v,
                               input int w, input int h, input int f);
    int r, g, b;
    r = $urandom_range(0, 255);
    g = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    start = (s != 0); abort = (a != 0); px.valid = (v != 0);
    px.iRed = 8'(r); px.iGreen = 8'(g); px.iBlue = 8'(b);
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_frames = 8'(f);

    e_err = 0; e_ovalid = 0; e_sof = 0; e_eol = 0; e_eof = 0;
    if (m_running != 0 && v != 0 && a == 0) begin
      e_ovalid = 1;
      e_r = r; e_g = g; e_b = b;
      e_x = m_idx % m_w;
      e_y = m_idx / m_w;
      e_sof = (m_idx == 0) ? 1 : 0;
      e_eol = (e_x == m_w - 1) ? 1 : 0;
      e_eof = (m_idx == m_w * m_h - 1) ? 1 : 0;
    end
    if (m_running == 0 && v != 0 && m_drops < 65535) m_drops++;
    if (a != 0) begin
      m_running = 0; m_finished = 0; m_idx = 0;
    end else if (m_running == 0) begin
      if (s != 0) begin
        if (w >= 1 && h >= 1) begin
          m_w = w; m_h = h; m_f = f;
          m_running = 1; m_finished = 0; m_idx = 0; m_frames = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (v != 0) begin
      m_idx++;
      if (m_idx == m_w * m_h) begin
        m_idx = 0;
        m_frames = (m_frames + 1) % 256;
        if (m_f != 0 && m_frames == m_f) begin
          m_running = 0; m_finished = 1;
        end
      end
    end

    @(posedge pixclk);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    @(negedge pixclk);
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; px.valid = 1'b0;
    repeat (2) @(negedge pixclk);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput();
  endtask

  initial begin
    int wrapped, done_seen, prev_fcnt;
    int rw, rh, rf;

    vecs[0] = '{1,0,0, 0,1,0,  0,0,0,0, 0,0,1, 0};
    vecs[1] = '{0,0,0, 0,1,0,  0,0,0,0, 0,0,0, 0};
    vecs[2] = '{1,0,0, 1,1,3,  0,0,0,0, 1,0,0, 0};
    vecs[3] = '{0,0,1, 7,7,7,  1,1,1,1, 1,0,0, 1};
    vecs[4] = '{0,0,1, 0,0,0,  1,1,1,1, 1,0,0, 2};
    vecs[5] = '{0,0,1, 2,2,2,  1,1,1,1, 0,1,0, 3};
    vecs[6] = '{0,0,1, 1,1,1,  0,0,0,0, 0,1,0, 3};
    vecs[7] = '{1,0,0, 3,0,1,  0,0,0,0, 0,1,1, 3};
    vecs[8] = '{1,1,0, 2,2,0,  0,0,0,0, 0,0,0, 3};

    px.valid = 1'b0; px.iRed = '0; px.iGreen = '0; px.iBlue = '0;
    modelReset();
    n_sof = 0; n_eol = 0; n_eof = 0;
    #12;
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput();

    $display("[TB] table vectors: degenerate sizes and config errors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].w, vecs[i].h, vecs[i].f);
      checkVal($sformatf("vec%0d.oValid", i), int'(px.oValid), vecs[i].ov);
      checkVal($sformatf("vec%0d.sof", i), int'(px.sof), vecs[i].sof);
      checkVal($sformatf("vec%0d.eol", i), int'(px.eol), vecs[i].eol);
      checkVal($sformatf("vec%0d.eof", i), int'(px.eof), vecs[i].eof);
      checkVal($sformatf("vec%0d.busy", i), int'(busy), vecs[i].busy);
      checkVal($sformatf("vec%0d.done", i), int'(done), vecs[i].done);
      checkVal($sformatf("vec%0d.cfg_err", i), int'(cfg_err), vecs[i].err);
      checkVal($sformatf("vec%0d.frame_cnt", i), int'(frame_cnt), vecs[i].fcnt);
    end

    $display("[TB] frame sequencing W=4 H=3 frames=2");
    resetDut();
    applyStimulus(1, 0, 0, 4, 3, 2);
    n_sof = 0; n_eol = 0; n_eof = 0;
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 1, 9, 9, 9);
    checkVal("seq.sof_count", n_sof, 2);
    checkVal("seq.eol_count", n_eol, 6);
    checkVal("seq.eof_count", n_eof, 2);
    checkVal("seq.frame_cnt", int'(frame_cnt), 2);
    checkVal("seq.done", int'(done), 1);
    checkVal("seq.busy", int'(busy), 0);

    $display("[TB] gapped stream W=4 H=2");
    applyStimulus(1, 0, 0, 4, 2, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, i % 2, 4, 2, 1);
    checkVal("gap.done", int'(done), 1);

    $display("[TB] drops and re-arm");
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 1, 1, 1);
    checkVal("drop.drop_cnt", int'(drop_cnt), 7);
    checkVal("drop.frame_cnt_before", int'(frame_cnt), 1);
    applyStimulus(1, 0, 0, 2, 2, 0);
    checkVal("drop.frame_cnt_rearm", int'(frame_cnt), 0);
    checkVal("drop.busy_rearm", int'(busy), 1);

    $display("[TB] abort mid-frame W=4 H=4");
    applyStimulus(1, 1, 0, 4, 4, 0);
    applyStimulus(1, 0, 0, 4, 4, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 4, 4, 0);
    applyStimulus(0, 1, 1, 4, 4, 0);
    checkVal("abort.busy", int'(busy), 0);
    checkVal("abort.eof", int'(px.eof), 0);
    applyStimulus(1, 1, 0, 4, 4, 0);
    checkVal("abort.start_same_cycle_busy", int'(busy), 0);
    applyStimulus(1, 0, 0, 4, 4, 0);
    applyStimulus(0, 0, 1, 4, 4, 0);
    checkVal("abort.restart_x", int'(px.x_coord), 0);
    checkVal("abort.restart_sof", int'(px.sof), 1);

    $display("[TB] async reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 4, 4, 0);
    #2;
    reset = 1'b1;
    #1;
    checkVal("rst.oValid", int'(px.oValid), 0);
    checkVal("rst.x_coord", int'(px.x_coord), 0);
    checkVal("rst.y_coord", int'(px.y_coord), 0);
    checkVal("rst.oRed", int'(px.oRed), 0);
    checkVal("rst.eol", int'(px.eol), 0);
    checkVal("rst.busy", int'(busy), 0);
    checkVal("rst.drop_cnt", int'(drop_cnt), 0);
    modelReset();
    @(negedge pixclk);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 4, 4, 0);

    $display("[TB] continuous mode W=2 H=1");
    applyStimulus(1, 0, 0, 2, 1, 0);
    wrapped = 0; done_seen = 0; prev_fcnt = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(0, 0, 1, 2, 1, 0);
      if (prev_fcnt == 255 && int'(frame_cnt) == 0) wrapped = 1;
      if (done) done_seen = 1;
      prev_fcnt = int'(frame_cnt);
    end
    checkVal("cont.wrapped", wrapped, 1);
    checkVal("cont.done_seen", done_seen, 0);
    checkVal("cont.frame_cnt", int'(frame_cnt), 44);

    $display("[TB] randomized traffic");
    for (int round = 0; round < 4; round++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, $urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 3));
      for (int i = 0; i < 200; i++) begin
        rw = $urandom_range(0, 5);
        rh = $urandom_range(0, 4);
        rf = $urandom_range(0, 3);
        applyStimulus(($urandom_range(0, 30) == 0) ? 1 : 0,
                      ($urandom_range(0, 60) == 0) ? 1 : 0,
                      ($urandom_range(0, 3) != 0) ? 1 : 0, rw, rh, rf);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
